// File: rtl/slink_gpio_rx_word_aligner_pkg.sv
// Shared definitions for the GPIO RX word aligner: FSM state encoding,
// default training word and a width helper for the match counter.
package slink_gpio_rx_word_aligner_pkg;

    // Encodings are fixed so they line up with the serdes and link layer views.
    typedef enum logic [1:0] {
        ALIGN_IDLE   = 2'd0,
        ALIGN_SEARCH = 2'd1,
        ALIGN_VERIFY = 2'd2,
        ALIGN_LOCKED = 2'd3
    } align_state_e;

    // Training word sent back to back, LSB first.
    localparam logic [7:0] SLINK_SYNC_PATTERN_DEFAULT = 8'hBC;

    // Counter width able to hold 0..lock_count inclusive.
    function automatic int unsigned cnt_width(input int unsigned lock_count);
        return $clog2(lock_count + 1);
    endfunction

endpackage

// File: rtl/slink_gpio_pattern_match.sv
// Combinational sync-word detector. Compares every bit offset of the
// two-word window against the training pattern and reports the lowest
// matching offset.
module slink_gpio_pattern_match #(
    parameter  int unsigned W     = 8,
    localparam int unsigned OFF_W = $clog2(W),
    localparam int unsigned CAT_W = 2 * W - 1
) (
    input  logic [CAT_W-1:0] cat_i,
    input  logic [W-1:0]     pattern_i,
    output logic [W-1:0]     match_vec_o,
    output logic             any_match_o,
    output logic [OFF_W-1:0] first_off_o
);

    // One comparator per candidate offset; candidate k starts at bit k.
    always_comb begin
        match_vec_o = '0;
        for (int k = 0; k < W; k++) begin
            match_vec_o[k] = (cat_i[k +: W] == pattern_i);
        end
    end

    assign any_match_o = |match_vec_o;

    // Priority encoder: scanning downwards lets the lowest match win.
    always_comb begin
        first_off_o = '0;
        for (int k = W - 1; k >= 0; k--) begin
            if (match_vec_o[k]) begin
                first_off_o = OFF_W'(k);
            end
        end
    end

endmodule

// File: rtl/slink_gpio_rx_word_aligner.sv
// Word aligner for the GPIO serdes RX path (phy_clk domain). Finds the bit
// offset of the repeating training word, confirms it over several words and
// then streams word-aligned data to the link layer until told to re-acquire.
//
// Output qualifier: aligned_valid marks aligned_data as a valid word in that
// cycle; there is no ready/backpressure, the link layer must take every word
// while aligned_valid is high. aligned_data is forced to 0 whenever
// aligned_valid is low.
module slink_gpio_rx_word_aligner
    import slink_gpio_rx_word_aligner_pkg::*;
#(
    parameter  int unsigned                PAR_DATA_WIDTH = 8,
    parameter  logic [PAR_DATA_WIDTH-1:0]  SYNC_PATTERN   = PAR_DATA_WIDTH'(SLINK_SYNC_PATTERN_DEFAULT),
    parameter  int unsigned                LOCK_COUNT     = 4,
    localparam int unsigned                OFF_W          = $clog2(PAR_DATA_WIDTH)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      relock,
    input  logic [PAR_DATA_WIDTH-1:0] rx_par_data,
    output logic [PAR_DATA_WIDTH-1:0] aligned_data,
    output logic                      aligned_valid,
    output logic                      locked,
    output logic [OFF_W-1:0]          offset,
    output logic                      lock_lost
);

    localparam int unsigned W     = PAR_DATA_WIDTH;
    localparam int unsigned CAT_W = 2 * W - 1;
    localparam int unsigned CNT_W = cnt_width(LOCK_COUNT);
    localparam logic [CNT_W-1:0] CNT_LOCK = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_COUNT - 1);

    align_state_e     state_q;
    logic [W-1:0]     prev_q;
    logic [W-1:0]     aligned_data_q;
    logic             aligned_valid_q;
    logic             locked_q;
    logic             lock_lost_q;
    logic [OFF_W-1:0] offset_q;
    logic [CNT_W-1:0] match_cnt_q;

    // The top bit of the current word can never be part of a candidate
    // (highest candidate ends at bit 2W-2), so the window stops short of it.
    logic [CAT_W-1:0] cat;
    logic [W-1:0]     match_vec;
    logic             any_match;
    logic [OFF_W-1:0] first_off;
    logic [W-1:0]     sel_cand;
    logic             sel_match;

    assign cat = {rx_par_data[W-2:0], prev_q};

    slink_gpio_pattern_match #(
        .W (W)
    ) u_pattern_match (
        .cat_i       (cat),
        .pattern_i   (SYNC_PATTERN),
        .match_vec_o (match_vec),
        .any_match_o (any_match),
        .first_off_o (first_off)
    );

    // Select the candidate word and its match bit at the offset in use.
    always_comb begin
        sel_cand  = '0;
        sel_match = 1'b0;
        for (int k = 0; k < W; k++) begin
            if (offset_q == OFF_W'(k)) begin
                sel_cand  = cat[k +: W];
                sel_match = match_vec[k];
            end
        end
    end

    // Alignment FSM with its counter, history word and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ALIGN_IDLE;
            prev_q          <= '0;
            aligned_data_q  <= '0;
            aligned_valid_q <= 1'b0;
            locked_q        <= 1'b0;
            lock_lost_q     <= 1'b0;
            offset_q        <= '0;
            match_cnt_q     <= '0;
        end else begin
            lock_lost_q <= 1'b0;
            prev_q      <= enable ? rx_par_data : '0;

            if (!enable) begin
                // Losing the enable always wins, including over relock.
                if ((state_q == ALIGN_VERIFY) || (state_q == ALIGN_LOCKED)) begin
                    lock_lost_q <= 1'b1;
                end
                state_q         <= ALIGN_IDLE;
                match_cnt_q     <= '0;
                aligned_data_q  <= '0;
                aligned_valid_q <= 1'b0;
                locked_q        <= 1'b0;
            end else begin
                case (state_q)
                    ALIGN_IDLE: begin
                        state_q <= ALIGN_SEARCH;
                    end

                    ALIGN_SEARCH: begin
                        if (any_match) begin
                            offset_q    <= first_off;
                            match_cnt_q <= CNT_W'(1);
                            if (LOCK_COUNT == 1) begin
                                // The matching candidate is the pattern itself.
                                state_q         <= ALIGN_LOCKED;
                                aligned_data_q  <= SYNC_PATTERN;
                                aligned_valid_q <= 1'b1;
                                locked_q        <= 1'b1;
                            end else begin
                                state_q <= ALIGN_VERIFY;
                            end
                        end
                    end

                    ALIGN_VERIFY: begin
                        if (relock) begin
                            state_q     <= ALIGN_SEARCH;
                            match_cnt_q <= '0;
                            lock_lost_q <= 1'b1;
                        end else if (sel_match) begin
                            if (match_cnt_q >= CNT_LAST) begin
                                // First delivered word is the last sync word.
                                state_q         <= ALIGN_LOCKED;
                                match_cnt_q     <= CNT_LOCK;
                                aligned_data_q  <= sel_cand;
                                aligned_valid_q <= 1'b1;
                                locked_q        <= 1'b1;
                            end else begin
                                match_cnt_q <= match_cnt_q + CNT_W'(1);
                            end
                        end else begin
                            state_q     <= ALIGN_SEARCH;
                            match_cnt_q <= '0;
                            lock_lost_q <= 1'b1;
                        end
                    end

                    ALIGN_LOCKED: begin
                        if (relock) begin
                            state_q         <= ALIGN_SEARCH;
                            match_cnt_q     <= '0;
                            lock_lost_q     <= 1'b1;
                            aligned_data_q  <= '0;
                            aligned_valid_q <= 1'b0;
                            locked_q        <= 1'b0;
                        end else begin
                            // Payload is not checked once locked.
                            aligned_data_q <= sel_cand;
                        end
                    end

                    default: begin
                        state_q <= ALIGN_IDLE;
                    end
                endcase
            end
        end
    end

    assign aligned_data  = aligned_data_q;
    assign aligned_valid = aligned_valid_q;
    assign locked        = locked_q;
    assign offset        = offset_q;
    assign lock_lost     = lock_lost_q;

endmodule

// File: tb/tb_slink_gpio_rx_word_aligner.sv
// Directed bench for the RX word aligner. dut_a uses the default 0xBC
// training word; dut_b uses 0xAA to exercise the lowest-offset priority.
module tb_slink_gpio_rx_word_aligner;

    logic       clk = 1'b0;
    logic       reset_n;

    logic       en_a, relock_a;
    logic [7:0] rx_a;
    logic [7:0] a_data;
    logic       a_valid, a_locked, a_lost;
    logic [2:0] a_off;

    logic       en_b, relock_b;
    logic [7:0] rx_b;
    logic [7:0] b_data;
    logic       b_valid, b_locked, b_lost;
    logic [2:0] b_off;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [7:0] last_a;
    int         sh_a;

    slink_gpio_rx_word_aligner #(
        .PAR_DATA_WIDTH (8),
        .SYNC_PATTERN   (8'hBC),
        .LOCK_COUNT     (4)
    ) dut_a (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (en_a),
        .relock        (relock_a),
        .rx_par_data   (rx_a),
        .aligned_data  (a_data),
        .aligned_valid (a_valid),
        .locked        (a_locked),
        .offset        (a_off),
        .lock_lost     (a_lost)
    );

    slink_gpio_rx_word_aligner #(
        .PAR_DATA_WIDTH (8),
        .SYNC_PATTERN   (8'hAA),
        .LOCK_COUNT     (4)
    ) dut_b (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (en_b),
        .relock        (relock_b),
        .rx_par_data   (rx_b),
        .aligned_data  (b_data),
        .aligned_valid (b_valid),
        .locked        (b_locked),
        .offset        (b_off),
        .lock_lost     (b_lost)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic [7:0] ed, input logic ev,
                           input logic el, input logic [2:0] eo, input logic ell);
        check({tag, ".data"},   32'(a_data),   32'(ed));
        check({tag, ".valid"},  32'(a_valid),  32'(ev));
        check({tag, ".locked"}, 32'(a_locked), 32'(el));
        check({tag, ".offset"}, 32'(a_off),    32'(eo));
        check({tag, ".lost"},   32'(a_lost),   32'(ell));
    endtask

    task automatic check_b(input string tag, input logic [7:0] ed, input logic ev,
                           input logic el, input logic [2:0] eo, input logic ell);
        check({tag, ".data"},   32'(b_data),   32'(ed));
        check({tag, ".valid"},  32'(b_valid),  32'(ev));
        check({tag, ".locked"}, 32'(b_locked), 32'(el));
        check({tag, ".offset"}, 32'(b_off),    32'(eo));
        check({tag, ".lost"},   32'(b_lost),   32'(ell));
    endtask

    // Drive a raw serdes word into dut_a for one cycle.
    task automatic send_a_raw(input logic [7:0] w);
        rx_a = w;
        tick();
    endtask

    // Drive the next word of a stream whose symbols sit sh_a bits late.
    task automatic send_a_sym(input logic [7:0] d);
        logic [15:0] t;
        t      = {d, last_a};
        rx_a   = t[(8 - sh_a) +: 8];
        last_a = d;
        tick();
    endtask

    task automatic send_b_raw(input logic [7:0] w);
        rx_b = w;
        tick();
    endtask

    initial begin
        reset_n  = 1'b0;
        en_a     = 1'b0;
        relock_a = 1'b0;
        rx_a     = 8'h00;
        en_b     = 1'b0;
        relock_b = 1'b0;
        rx_b     = 8'h00;
        last_a   = 8'h00;
        sh_a     = 0;

        // Reset state
        tick();
        check_a("rst_a", 8'h00, 0, 0, 3'd0, 0);
        check_b("rst_b", 8'h00, 0, 0, 3'd0, 0);
        reset_n = 1'b1;

        // Test 1: stream shifted by 3 bits, lock on the 4th match
        en_a = 1'b1;
        sh_a = 3;
        send_a_sym(8'hBC);
        check_a("t1_idle", 8'h00, 0, 0, 3'd0, 0);
        send_a_sym(8'hBC);
        send_a_sym(8'hBC);
        send_a_sym(8'hBC);
        check_a("t1_pre", 8'h00, 0, 0, 3'd3, 0);
        send_a_sym(8'hBC);
        check_a("t1_lock", 8'hBC, 1, 1, 3'd3, 0);
        send_a_sym(8'h5A);
        check_a("t1_p0", 8'hBC, 1, 1, 3'd3, 0);
        send_a_sym(8'h00);
        check_a("t1_p1", 8'h5A, 1, 1, 3'd3, 0);
        send_a_sym(8'hFF);
        check_a("t1_p2", 8'h00, 1, 1, 3'd3, 0);
        send_a_sym(8'hBC);
        check_a("t1_p3", 8'hFF, 1, 1, 3'd3, 0);

        // Test 6a: enable drop while locked
        en_a = 1'b0;
        send_a_sym(8'hBC);
        check_a("t6_en_drop", 8'h00, 0, 0, 3'd3, 1);
        send_a_sym(8'hBC);
        check_a("t6_idle", 8'h00, 0, 0, 3'd3, 0);

        // Test 2: aligned stream, offset 0
        en_a = 1'b1;
        sh_a = 0;
        send_a_sym(8'hBC);
        check_a("t2_idle", 8'h00, 0, 0, 3'd3, 0);
        send_a_sym(8'hBC);
        send_a_sym(8'hBC);
        send_a_sym(8'hBC);
        check_a("t2_pre", 8'h00, 0, 0, 3'd0, 0);
        send_a_sym(8'hBC);
        check_a("t2_lock", 8'hBC, 1, 1, 3'd0, 0);

        // Test 5: relock in LOCKED, reacquire at offset 6
        relock_a = 1'b1;
        send_a_raw(8'h00);
        relock_a = 1'b0;
        check_a("t5_relock", 8'h00, 0, 0, 3'd0, 1);
        last_a = 8'h00;
        sh_a   = 6;
        send_a_sym(8'hBC);
        check_a("t5_search", 8'h00, 0, 0, 3'd0, 0);
        send_a_sym(8'hBC);
        send_a_sym(8'hBC);
        send_a_sym(8'hBC);
        check_a("t5_pre", 8'h00, 0, 0, 3'd6, 0);
        send_a_sym(8'hBC);
        check_a("t5_lock", 8'hBC, 1, 1, 3'd6, 0);

        // Test 3: VERIFY failure after two good words
        relock_a = 1'b1;
        send_a_raw(8'h00);
        relock_a = 1'b0;
        check_a("t3_relock", 8'h00, 0, 0, 3'd6, 1);
        last_a = 8'h00;
        send_a_sym(8'hBC);
        send_a_sym(8'hBC);
        send_a_sym(8'hBC);
        check_a("t3_two_good", 8'h00, 0, 0, 3'd6, 0);
        send_a_raw(8'h00);
        check_a("t3_corrupt", 8'h00, 0, 0, 3'd6, 1);
        last_a = 8'h00;
        send_a_sym(8'hBC);
        check_a("t3_search", 8'h00, 0, 0, 3'd6, 0);
        send_a_sym(8'hBC);
        send_a_sym(8'hBC);
        send_a_sym(8'hBC);
        check_a("t3_no_early", 8'h00, 0, 0, 3'd6, 0);
        send_a_sym(8'hBC);
        check_a("t3_lock", 8'hBC, 1, 1, 3'd6, 0);

        // Test 6b: async reset while in VERIFY
        relock_a = 1'b1;
        send_a_raw(8'h00);
        relock_a = 1'b0;
        check_a("t6_relock", 8'h00, 0, 0, 3'd6, 1);
        last_a = 8'h00;
        send_a_sym(8'hBC);
        send_a_sym(8'hBC);
        send_a_sym(8'hBC);
        check_a("t6_verify", 8'h00, 0, 0, 3'd6, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check_a("t6_async_rst", 8'h00, 0, 0, 3'd0, 0);
        #2;
        reset_n = 1'b1;
        send_a_raw(8'hBC);
        check_a("t6_reen", 8'h00, 0, 0, 3'd0, 0);
        send_a_raw(8'hBC);
        send_a_raw(8'hBC);
        send_a_raw(8'hBC);
        check_a("t6_pre", 8'h00, 0, 0, 3'd0, 0);
        send_a_raw(8'hBC);
        check_a("t6_relocked", 8'hBC, 1, 1, 3'd0, 0);

        // relock and enable-low together: IDLE wins, lock_lost still pulses
        relock_a = 1'b1;
        en_a     = 1'b0;
        send_a_raw(8'hBC);
        relock_a = 1'b0;
        check_a("t6_both", 8'h00, 0, 0, 3'd0, 1);
        send_a_raw(8'hBC);
        check_a("t6_idle2", 8'h00, 0, 0, 3'd0, 0);

        // Test 4: ambiguous pattern 0xAA shifted by 1, lowest offset wins
        en_b = 1'b1;
        send_b_raw(8'h55);
        check_b("t4_idle", 8'h00, 0, 0, 3'd0, 0);
        send_b_raw(8'h55);
        send_b_raw(8'h55);
        send_b_raw(8'h55);
        check_b("t4_pre", 8'h00, 0, 0, 3'd1, 0);
        send_b_raw(8'h55);
        check_b("t4_lock", 8'hAA, 1, 1, 3'd1, 0);
        send_b_raw(8'h79);
        check_b("t4_p0", 8'hAA, 1, 1, 3'd1, 0);
        send_b_raw(8'h00);
        check_b("t4_p1", 8'h3C, 1, 1, 3'd1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
